// File: rtl/tmds_decoder.sv
// One TMDS receive channel: hunts the 10-bit word boundary on control tokens, holds lock, decodes symbols.
// Define TMDS_DECODER_ERRCNT_EN to add err_count_out, a saturating count of lock losses and failed confirms.
module tmds_decoder #(
    parameter int SEARCH_LEN  = 2048,
    parameter int LOCK_TOKENS = 16,
    parameter int LOSS_LEN    = 4096
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [9:0]  tmds_in,
    output logic [7:0]  data_out,
    output logic [1:0]  control_out,
    output logic        ve_out,
    output logic        locked_out,
    output logic [3:0]  offset_out
`ifdef TMDS_DECODER_ERRCNT_EN
    ,
    output logic [15:0] err_count_out
`endif
);

    localparam int CNT_MAX_SL = (SEARCH_LEN > LOCK_TOKENS) ? SEARCH_LEN : LOCK_TOKENS;
    localparam int CNT_MAX    = (CNT_MAX_SL > LOSS_LEN) ? CNT_MAX_SL : LOSS_LEN;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SEARCH_LAST = CNT_W'(SEARCH_LEN - 1);
    localparam logic [CNT_W-1:0] LOCK_NEED   = CNT_W'(LOCK_TOKENS);
    localparam logic [CNT_W-1:0] LOSS_LAST   = CNT_W'(LOSS_LEN);

    localparam logic [9:0] TOK_00 = 10'b1101010100;
    localparam logic [9:0] TOK_01 = 10'b0010101011;
    localparam logic [9:0] TOK_10 = 10'b0101010100;
    localparam logic [9:0] TOK_11 = 10'b1010101011;

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_CONFIRM,
        ST_LOCKED
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [3:0]       offset_reg;
    logic             locked_reg;
    logic [9:0]       raw_q_reg;
    logic [9:0]       raw_qq_reg;
    logic [9:0]       sym_reg;
    logic             sym_tok_reg;
    logic [1:0]       sym_ctrl_reg;
    logic [7:0]       data_reg;
    logic [1:0]       ctrl_reg;
    logic             ve_reg;

    // Bit 19 of the full window is never reachable with offsets 0..9.
    logic [18:0] window;
    logic [9:0]  cand [10];
    logic [9:0]  sym;
    logic        is_tok;
    logic [1:0]  tok_val;

    assign window = {raw_q_reg[8:0], raw_qq_reg};

    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_cand
            assign cand[gi] = window[gi+9:gi];
        end
    endgenerate

    always_comb begin
        sym = cand[0];
        for (int i = 1; i < 10; i++) begin
            if (offset_reg == 4'(i)) begin
                sym = cand[i];
            end
        end
    end

    always_comb begin
        is_tok  = 1'b1;
        tok_val = 2'b00;
        case (sym)
            TOK_00:  tok_val = 2'b00;
            TOK_01:  tok_val = 2'b01;
            TOK_10:  tok_val = 2'b10;
            TOK_11:  tok_val = 2'b11;
            default: is_tok  = 1'b0;
        endcase
    end

    // Symbol decode works on the registered symbol, one stage behind the aligner.
    logic [7:0] dinv;
    logic [7:0] dec;

    assign dinv   = sym_reg[9] ? ~sym_reg[7:0] : sym_reg[7:0];
    assign dec[0] = dinv[0];

    generate
        for (gi = 1; gi < 8; gi++) begin : g_dec
            assign dec[gi] = sym_reg[8] ? (dinv[gi] ^ dinv[gi-1]) : ~(dinv[gi] ^ dinv[gi-1]);
        end
    endgenerate

    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       offset_slip;

    assign cnt_inc     = cnt_reg + CNT_W'(1);
    assign offset_slip = (offset_reg == 4'd9) ? 4'd0 : offset_reg + 4'd1;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg    <= ST_SEARCH;
            cnt_reg      <= '0;
            offset_reg   <= 4'd0;
            locked_reg   <= 1'b0;
            raw_q_reg    <= 10'd0;
            raw_qq_reg   <= 10'd0;
            sym_reg      <= 10'd0;
            sym_tok_reg  <= 1'b0;
            sym_ctrl_reg <= 2'b00;
            data_reg     <= 8'd0;
            ctrl_reg     <= 2'b00;
            ve_reg       <= 1'b0;
        end else begin
            raw_q_reg    <= tmds_in;
            raw_qq_reg   <= raw_q_reg;
            sym_reg      <= sym;
            sym_tok_reg  <= is_tok;
            sym_ctrl_reg <= tok_val;

            // locked_reg here is the lock state that resulted from judging sym_reg.
            if (!locked_reg) begin
                data_reg <= 8'd0;
                ctrl_reg <= 2'b00;
                ve_reg   <= 1'b0;
            end else if (sym_tok_reg) begin
                ctrl_reg <= sym_ctrl_reg;
                ve_reg   <= 1'b0;
            end else begin
                data_reg <= dec;
                ve_reg   <= 1'b1;
            end

            case (state_reg)
                ST_SEARCH: begin
                    if (is_tok) begin
                        state_reg <= ST_CONFIRM;
                        cnt_reg   <= CNT_W'(1);
                    end else if (cnt_inc == SEARCH_LAST) begin
                        offset_reg <= offset_slip;
                        cnt_reg    <= '0;
                    end else begin
                        cnt_reg <= cnt_inc;
                    end
                end
                ST_CONFIRM: begin
                    if (is_tok) begin
                        if (cnt_inc == LOCK_NEED) begin
                            state_reg  <= ST_LOCKED;
                            locked_reg <= 1'b1;
                            cnt_reg    <= '0;
                        end else begin
                            cnt_reg <= cnt_inc;
                        end
                    end else begin
                        state_reg  <= ST_SEARCH;
                        offset_reg <= offset_slip;
                        cnt_reg    <= '0;
                    end
                end
                ST_LOCKED: begin
                    if (is_tok) begin
                        cnt_reg <= '0;
                    end else if (cnt_inc == LOSS_LAST) begin
                        state_reg  <= ST_SEARCH;
                        locked_reg <= 1'b0;
                        cnt_reg    <= '0;
                    end else begin
                        cnt_reg <= cnt_inc;
                    end
                end
                default: begin
                    state_reg  <= ST_SEARCH;
                    locked_reg <= 1'b0;
                    cnt_reg    <= '0;
                end
            endcase
        end
    end

    assign data_out    = data_reg;
    assign control_out = ctrl_reg;
    assign ve_out      = ve_reg;
    assign locked_out  = locked_reg;
    assign offset_out  = offset_reg;

`ifdef TMDS_DECODER_ERRCNT_EN
    logic [15:0] err_reg;
    logic        fail_event;

    assign fail_event = (state_reg == ST_CONFIRM && !is_tok) ||
                        (state_reg == ST_LOCKED && !is_tok && cnt_inc == LOSS_LAST);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            err_reg <= 16'd0;
        end else if (fail_event && err_reg != 16'hFFFF) begin
            err_reg <= err_reg + 16'd1;
        end
    end

    assign err_count_out = err_reg;
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// Self-checking bench for tmds_decoder: bit-level stream builder plus a rule-level reference model.
module tb_tmds_decoder;

    localparam int SEARCH_LEN  = 2048;
    localparam int LOCK_TOKENS = 16;
    localparam int LOSS_LEN    = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] tmds = 10'd0;
    logic [7:0] data;
    logic [1:0] control;
    logic       ve;
    logic       locked;
    logic [3:0] offset;
`ifdef TMDS_DECODER_ERRCNT_EN
    logic [15:0] err_count;
`endif

    tmds_decoder #(
        .SEARCH_LEN (SEARCH_LEN),
        .LOCK_TOKENS(LOCK_TOKENS),
        .LOSS_LEN   (LOSS_LEN)
    ) dut (
        .clk_in     (clk),
        .rst_in     (rst),
        .tmds_in    (tmds),
        .data_out   (data),
        .control_out(control),
        .ve_out     (ve),
        .locked_out (locked),
        .offset_out (offset)
`ifdef TMDS_DECODER_ERRCNT_EN
        ,
        .err_count_out(err_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [31:0] got, input logic [31:0] exp);
        $display("step %s observed=%0h expected=%0h", tag, got, exp);
        chk(tag, got, exp);
    endtask

    // ---------------- reference helpers ----------------
    logic [9:0] toks [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

    function automatic int tok_code(input logic [9:0] s);
        for (int i = 0; i < 4; i++) begin
            if (s == toks[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [7:0] qm_of(input logic [7:0] b, input logic xor_mode);
        logic [7:0] q;
        q[0] = b[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = xor_mode ? (q[i-1] ^ b[i]) : ~(q[i-1] ^ b[i]);
        end
        return q;
    endfunction

    function automatic logic [9:0] enc_sym(input logic [7:0] b, input logic xor_mode, input logic inv);
        logic [7:0] q;
        q = qm_of(b, xor_mode);
        return {inv, xor_mode, inv ? ~q : q};
    endfunction

    // Decode by finding the byte whose encoding reproduces the symbol.
    function automatic logic [7:0] ref_decode(input logic [9:0] s);
        logic [7:0] d;
        d = s[9] ? ~s[7:0] : s[7:0];
        for (int b = 0; b < 256; b++) begin
            if (qm_of(8'(b), s[8]) == d) return 8'(b);
        end
        return 8'd0;
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] s;
        do begin
            s = enc_sym(8'($urandom), 1'($urandom), 1'($urandom));
        end while (tok_code(s) >= 0);
        return s;
    endfunction

    // ---------------- reference model ----------------
    int hist[$];
    int m_state;
    int m_cnt;
    int m_off;
    int m_err;
    int p_sym;
    bit p_lock;
    int e_data, e_ctrl, e_ve;

    task automatic model_reset();
        hist.delete();
        hist.push_back(0);
        hist.push_back(0);
        m_state = 0; m_cnt = 0; m_off = 0; m_err = 0;
        p_sym = 0; p_lock = 0;
        e_data = 0; e_ctrl = 0; e_ve = 0;
    endtask

    task automatic model_step(input logic r, input logic [9:0] w);
        int win, sym, tc, tp;
        if (r) begin
            model_reset();
        end else begin
            tp = tok_code(10'(p_sym));
            if (!p_lock) begin
                e_data = 0; e_ctrl = 0; e_ve = 0;
            end else if (tp >= 0) begin
                e_ve = 0; e_ctrl = tp;
            end else begin
                e_ve = 1; e_data = int'(ref_decode(10'(p_sym)));
            end
            win = (hist[1] << 10) | hist[0];
            sym = (win >> m_off) & 'h3ff;
            tc  = tok_code(10'(sym));
            case (m_state)
                0: begin
                    if (tc >= 0) begin
                        m_state = 1; m_cnt = 1;
                    end else begin
                        m_cnt++;
                        if (m_cnt == SEARCH_LEN - 1) begin
                            m_off = (m_off + 1) % 10; m_cnt = 0;
                        end
                    end
                end
                1: begin
                    if (tc >= 0) begin
                        m_cnt++;
                        if (m_cnt == LOCK_TOKENS) begin
                            m_state = 2; m_cnt = 0;
                        end
                    end else begin
                        m_state = 0; m_off = (m_off + 1) % 10; m_cnt = 0;
                        if (m_err < 'hFFFF) m_err++;
                    end
                end
                default: begin
                    if (tc >= 0) begin
                        m_cnt = 0;
                    end else begin
                        m_cnt++;
                        if (m_cnt == LOSS_LEN) begin
                            m_state = 0; m_cnt = 0;
                            if (m_err < 'hFFFF) m_err++;
                        end
                    end
                end
            endcase
            p_sym  = sym;
            p_lock = (m_state == 2);
            void'(hist.pop_front());
            hist.push_back(int'(w));
        end
    endtask

    // ---------------- cycle driver ----------------
    int cyc = 0;
    int lock_cyc = 0;
    bit lock_seen = 0;

    task automatic tick(input logic r, input logic [9:0] w);
        rst  = r;
        tmds = w;
        @(posedge clk);
        #1;
        model_step(r, w);
        cyc++;
        if (!lock_seen && locked) begin
            lock_seen = 1;
            lock_cyc  = cyc;
        end
        chk("data_out", 32'(data), 32'(e_data));
        chk("control_out", 32'(control), 32'(e_ctrl));
        chk("ve_out", 32'(ve), 32'(e_ve));
        chk("locked_out", 32'(locked), 32'(p_lock));
        chk("offset_out", 32'(offset), 32'(m_off));
`ifdef TMDS_DECODER_ERRCNT_EN
        chk("err_count_out", 32'(err_count), 32'(m_err));
`endif
    endtask

    // ---------------- serial bit stream ----------------
    bit bq[$];
    int n_pushed = 0;

    task automatic push_sym(input logic [9:0] s);
        for (int i = 0; i < 10; i++) bq.push_back(s[i]);
        n_pushed += 10;
    endtask

    task automatic pad_to(input int o, input bit rnd);
        while (n_pushed % 10 != o) begin
            bq.push_back(rnd ? 1'($urandom) : 1'b0);
            n_pushed++;
        end
    endtask

    task automatic flush();
        logic [9:0] w;
        while (bq.size() >= 10) begin
            for (int i = 0; i < 10; i++) w[i] = bq.pop_front();
            tick(1'b0, w);
        end
    endtask

    task automatic push_line();
        repeat (370) push_sym(toks[0]);
        repeat (1280) push_sym(rand_data());
    endtask

    task automatic do_reset();
        bq.delete();
        n_pushed = 0;
        tick(1'b1, 10'($urandom));
        cyc = 0;
        lock_seen = 0;
        lock_cyc = 0;
    endtask

    logic [9:0] a5_sym;

    initial begin
        model_reset();
        a5_sym = enc_sym(8'hA5, 1'b1, 1'b0);

        // Reset state
        tick(1'b1, 10'd0);
        do_reset();
        step("reset_locked", 32'(locked), 0);
        step("reset_offset", 32'(offset), 0);
        step("reset_ve", 32'(ve), 0);
        step("reset_data", 32'(data), 0);

        // Aligned lock at offset 0: 17 tokens not yet locked, the 18th edge locks
        repeat (17) push_sym(toks[0]);
        flush();
        step("t1_before_lock", 32'(locked), 0);
        push_sym(toks[0]);
        flush();
        step("t1_locked_after_16", 32'(locked), 1);
        repeat (352) push_sym(toks[0]);
        flush();
        step("t1_offset", 32'(offset), 0);
        repeat (3) push_sym(a5_sym);
        flush();
        step("t1_ve_latency_3", 32'(ve), 0);
        push_sym(a5_sym);
        flush();
        step("t1_ve_data", 32'(ve), 1);
        step("t1_data_a5", 32'(data), 32'h A5);

        // Control tokens while locked
        for (int v = 1; v < 4; v++) begin
            repeat (6) push_sym(toks[v]);
            flush();
            step("t3_control", 32'(control), 32'(v));
            step("t3_ve_low", 32'(ve), 0);
        end

        // Loss of lock after LOSS_LEN non-token symbols
        repeat (LOSS_LEN + 1) push_sym(rand_data());
        flush();
        step("t4_still_locked", 32'(locked), 1);
        push_sym(rand_data());
        flush();
        step("t4_lock_lost", 32'(locked), 0);
        step("t4_offset_kept", 32'(offset), 0);
`ifdef TMDS_DECODER_ERRCNT_EN
        step("t4_err_count", 32'(err_count), 1);
`endif

        // Confirm failure slips the offset, including the 9 -> 0 wrap
        for (int o = 0; o < 10; o++) begin
            pad_to(o, 1'b0);
            repeat (5) push_sym(toks[0]);
            repeat (4) push_sym(10'd0);
            flush();
            step("t5_offset_slip", 32'(offset), 32'((o + 1) % 10));
        end
        step("t5_unlocked", 32'(locked), 0);

        // Stream rotated by 7 bits with 720p-like lines
        do_reset();
        pad_to(7, 1'b1);
        for (int ln = 0; ln < 14 && !lock_seen; ln++) begin
            push_line();
            flush();
        end
        step("t2_lock_seen", 32'(lock_seen), 1);
        step("t2_lock_in_bound", 32'(lock_cyc <= 10 * SEARCH_LEN + LOCK_TOKENS), 1);
        repeat (2) begin
            push_line();
            flush();
        end
        step("t2_offset_7", 32'(offset), 7);
        step("t2_locked", 32'(locked), 1);

        // Reset pulse while locked
        do_reset();
        step("t6_locked", 32'(locked), 0);
        step("t6_offset", 32'(offset), 0);
        step("t6_data", 32'(data), 0);
        step("t6_control", 32'(control), 0);
        step("t6_ve", 32'(ve), 0);
        repeat (4) tick(1'b0, 10'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
